tt_um_reuel_pandher_lut_circuit: RTL and testbench

// - Programmable successor of the fixed 3-input gate circuit: NUM_LUT independent 3-input lookup tables.
// - All LUTs share inputs A,B,C and drive registered outputs.
// - Truth tables reload at run time over a synchronised 3-wire serial config port.
// - Reset defaults reproduce the legacy function: out0 = (A&B)|~C, out1 = ~C.
// - Adds a transition counter on out0. Sits as the Tiny Tapeout user top.

---
 rtl/tt_lut_pkg.sv | 28 ++
 rtl/tt_lut_cfg_if.sv | 23 ++
 rtl/lut_cfg_loader.sv | 80 ++++++++
 rtl/tt_um_reuel_pandher_lut_circuit.sv | 84 ++++++++
 tb/tb_tt_um_reuel_pandher_lut_circuit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_lut_pkg.sv
// Shared constants for the programmable LUT circuit: config FSM encoding,
// legacy truth tables and ui_in bit positions.
package tt_lut_pkg;

    typedef logic [1:0] cfg_state_t;

    localparam cfg_state_t ST_IDLE   = 2'd0;
    localparam cfg_state_t ST_SHIFT  = 2'd1;
    localparam cfg_state_t ST_COMMIT = 2'd2;

    // out0 = (A&B)|~C and out1 = ~C, indexed by {C,B,A}
    localparam logic [7:0] TT_LEGACY_X = 8'h8F;
    localparam logic [7:0] TT_LEGACY_Y = 8'h0F;

    localparam int UI_A        = 0;
    localparam int UI_B        = 1;
    localparam int UI_C        = 2;
    localparam int UI_CFG_EN   = 3;
    localparam int UI_CFG_DATA = 4;
    localparam int UI_CFG_CLK  = 5;
    localparam int UI_HOLD     = 6;
    localparam int UI_UNUSED   = 7;

    function automatic logic lut_eval(input logic [7:0] tt, input logic [2:0] idx);
        return tt[idx];
    endfunction

endpackage

// File: rtl/tt_lut_cfg_if.sv
// Link between the top (synchronised config pins in, table image out) and
// the serial config loader.
interface lut_cfg_if #(
    parameter int NUM_LUT = 2
);
    logic                 cfg_en;
    logic                 cfg_data;
    logic                 cfg_clk;
    logic                 commit;
    logic                 busy;
    logic                 error;
    logic [NUM_LUT*8-1:0] sr;

    modport master (
        output cfg_en, cfg_data, cfg_clk,
        input  commit, busy, error, sr
    );

    modport slave (
        input  cfg_en, cfg_data, cfg_clk,
        output commit, busy, error, sr
    );
endinterface

// File: rtl/lut_cfg_loader.sv
// Serial truth-table loader: edge detect on the synchronised pins, shift
// register with saturating bit count, and the commit/error decision.
//   state  | meaning
//   IDLE   | waiting for cfg_en to rise
//   SHIFT  | shifting one bit per cfg_clk rise while cfg_en is high
//   COMMIT | one cycle, top copies sr into the table registers
module lut_cfg_loader
    import tt_lut_pkg::*;
#(
    parameter int NUM_LUT = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    lut_cfg_if.slave  bus
);

    localparam int W  = NUM_LUT * 8;
    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(W);
    localparam logic [CW-1:0] CNT_SAT  = CW'(W + 1);

    cfg_state_t    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  sr;
    logic          error;
    logic          en_d;
    logic          clk_d;
    logic          en_rise;
    logic          en_fall;
    logic          clk_rise;

    assign en_rise  =  bus.cfg_en  & ~en_d;
    assign en_fall  = ~bus.cfg_en  &  en_d;
    assign clk_rise =  bus.cfg_clk & ~clk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sr    <= '0;
            error <= 1'b0;
            en_d  <= 1'b0;
            clk_d <= 1'b0;
        end else begin
            en_d  <= bus.cfg_en;
            clk_d <= bus.cfg_clk;
            case (state)
                ST_IDLE: begin
                    if (en_rise) begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                        error <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // a cfg_clk rise coinciding with the fall is dropped
                    if (en_fall) begin
                        if (cnt == CNT_FULL) begin
                            state <= ST_COMMIT;
                        end else begin
                            state <= ST_IDLE;
                            error <= 1'b1;
                        end
                    end else if (clk_rise && bus.cfg_en) begin
                        sr <= {sr[W-2:0], bus.cfg_data};
                        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
                    end
                end
                ST_COMMIT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign bus.commit = (state == ST_COMMIT);
    assign bus.busy   = (state != ST_IDLE);
    assign bus.error  = error;
    assign bus.sr     = sr;

endmodule

// File: rtl/tt_um_reuel_pandher_lut_circuit.sv
// Tiny Tapeout top: NUM_LUT run-time programmable 3-input LUTs on shared
// synchronised inputs, with registered outputs and an out0 transition counter.
module tt_um_reuel_pandher_lut_circuit
    import tt_lut_pkg::*;
#(
    parameter int                   NUM_LUT    = 2,
    parameter logic [NUM_LUT*8-1:0] TT_DEFAULT = {TT_LEGACY_Y, TT_LEGACY_X},
    parameter int                   SYNC_STG   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [SYNC_STG*7-1:0] sync_q;
    logic [6:0]            s;
    logic [2:0]            idx;
    logic [NUM_LUT*8-1:0]  tables;
    logic [NUM_LUT-1:0]    lut_q;
    logic [NUM_LUT-1:0]    lut_next;
    logic [7:0]            trans_cnt;

    lut_cfg_if #(.NUM_LUT(NUM_LUT)) cfg_bus ();

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[(SYNC_STG-1)*7-1:0], ui_in[6:0]};
    end

    assign s   = sync_q[SYNC_STG*7-1 -: 7];
    assign idx = {s[UI_C], s[UI_B], s[UI_A]};

    assign cfg_bus.cfg_en   = s[UI_CFG_EN];
    assign cfg_bus.cfg_data = s[UI_CFG_DATA];
    assign cfg_bus.cfg_clk  = s[UI_CFG_CLK];

    lut_cfg_loader #(.NUM_LUT(NUM_LUT)) u_loader (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cfg_bus)
    );

    // sr byte k is already aligned with LUT k, so the image copies whole
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              tables <= TT_DEFAULT;
        else if (cfg_bus.commit) tables <= cfg_bus.sr;
    end

    always_comb begin
        lut_next = '0;
        for (int k = 0; k < NUM_LUT; k++) begin
            lut_next[k] = lut_eval(tables[k*8 +: 8], idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_q     <= '0;
            trans_cnt <= '0;
        end else if (!s[UI_HOLD]) begin
            lut_q <= lut_next;
            if (lut_next[0] != lut_q[0]) trans_cnt <= trans_cnt + 8'd1;
        end
    end

    always_comb begin
        uo_out              = '0;
        uo_out[NUM_LUT-1:0] = lut_q;
        uo_out[6]           = cfg_bus.busy;
        uo_out[7]           = cfg_bus.error;
    end

    assign uio_out = trans_cnt;
    assign uio_oe  = 8'hFF;

    logic _unused;
    assign _unused = &{ena, uio_in, ui_in[UI_UNUSED], 1'b0};

endmodule

// File: tb/tb_tt_um_reuel_pandher_lut_circuit.sv
// Randomised self-checking bench against a truth-table/transition-count model.
module tb_tt_um_reuel_pandher_lut_circuit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

    logic a = 0, b = 0, c = 0, cfg_en = 0, cfg_data = 0, cfg_clk = 0, hold = 0, spare = 0;
    logic [7:0] noise = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_tt;
    logic [1:0]  m_out;
    logic [7:0]  m_cnt;
    logic        m_err;

    assign ui_in  = {spare, hold, cfg_clk, cfg_data, cfg_en, c, b, a};
    assign uio_in = noise;

    always #5 clk = ~clk;

    tt_um_reuel_pandher_lut_circuit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_uo(input logic busy);
        return {m_err, busy, 4'b0000, m_out};
    endfunction

    // one settled evaluation of the reference: LUT k output = bit idx of table k
    task automatic update_model(input logic [2:0] idx);
        logic [1:0] nx;
        if (!hold) begin
            nx[0] = m_tt[idx];
            nx[1] = m_tt[8 + idx];
            if (nx[0] != m_out[0]) m_cnt = m_cnt + 8'd1;
            m_out = nx;
        end
    endtask

    task automatic apply_reset();
        rst_n = 0; cfg_en = 0; cfg_clk = 0; cfg_data = 0; hold = 0;
        tick(2);
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo got %h exp 00", uo_out); end
        checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_cnt got %h exp 00", uio_out); end
        checks++; if (uio_oe !== 8'hFF) begin errors++; $display("FAIL uio_oe got %h exp FF", uio_oe); end
        rst_n = 1;
        m_tt = 16'h0F8F; m_out = 2'b00; m_cnt = 8'd0; m_err = 0;
        tick(4);
        update_model(3'd0);
        update_model({c, b, a});
        checks++; if (uo_out !== exp_uo(0)) begin errors++; $display("FAIL post_reset_uo got %h exp %h", uo_out, exp_uo(0)); end
        checks++; if (uio_out !== m_cnt) begin errors++; $display("FAIL post_reset_cnt got %h exp %h", uio_out, m_cnt); end
    endtask

    // sends word[n-1] first; clk_at_fall raises cfg_clk together with the cfg_en fall
    task automatic cfg_load(input logic [31:0] word, input int n, input bit clk_at_fall);
        cfg_en = 1;
        tick(3);
        for (int i = n - 1; i >= 0; i--) begin
            cfg_data = word[i];
            tick(2);
            cfg_clk = 1;
            tick(2);
            cfg_clk = 0;
            tick(2);
        end
        checks++; if (uo_out[6] !== 1'b1) begin errors++; $display("FAIL busy_in_load got %b exp 1", uo_out[6]); end
        cfg_data = 1'($urandom);
        if (clk_at_fall) cfg_clk = 1;
        cfg_en = 0;
        tick(6);
        cfg_clk = 0;
        tick(2);
        if (n == 16) begin
            m_tt  = word[15:0];
            m_err = 0;
        end else begin
            m_err = 1;
        end
        update_model({c, b, a});
        checks++; if (uo_out !== exp_uo(0)) begin errors++; $display("FAIL after_load n=%0d got %h exp %h", n, uo_out, exp_uo(0)); end
        checks++; if (uio_out !== m_cnt) begin errors++; $display("FAIL load_cnt got %h exp %h", uio_out, m_cnt); end
    endtask

    task automatic random_sweep(input int n);
        for (int i = 0; i < n; i++) begin
            {c, b, a} = 3'($urandom);
            spare = 1'($urandom);
            noise = 8'($urandom);
            tick(3);
            update_model({c, b, a});
            checks++; if (uo_out !== exp_uo(0)) begin errors++; $display("FAIL sweep abc=%0d got %h exp %h", {c, b, a}, uo_out, exp_uo(0)); end
        end
        checks++; if (uio_out !== m_cnt) begin errors++; $display("FAIL sweep_cnt got %h exp %h", uio_out, m_cnt); end
    endtask

    task automatic test_reset();
        {c, b, a} = 3'd0;
        apply_reset();
    endtask

    task automatic test_legacy_sweep();
        logic [7:0] l0, l1, prev;
        l0 = 8'h8F; l1 = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            prev = uo_out;
            {c, b, a} = i[2:0];
            tick(2);
            checks++; if (uo_out !== prev) begin errors++; $display("FAIL latency abc=%0d got %h exp %h", i, uo_out, prev); end
            tick(1);
            update_model(i[2:0]);
            checks++; if (uo_out[1:0] !== {l1[i], l0[i]}) begin errors++; $display("FAIL legacy abc=%0d got %b exp %b", i, uo_out[1:0], {l1[i], l0[i]}); end
            checks++; if (uo_out !== exp_uo(0)) begin errors++; $display("FAIL legacy_uo abc=%0d got %h exp %h", i, uo_out, exp_uo(0)); end
        end
        checks++; if (uio_out !== m_cnt) begin errors++; $display("FAIL legacy_cnt got %h exp %h", uio_out, m_cnt); end
    endtask

    task automatic test_load_bad();
        cfg_load(32'($urandom), 15, 0);
        random_sweep(4);
        cfg_load(32'($urandom), 17, 0);
        tick(5);
        checks++; if (uo_out[7] !== 1'b1) begin errors++; $display("FAIL error_sticky got %b exp 1", uo_out[7]); end
        random_sweep(4);
        cfg_load(32'($urandom), $urandom_range(0, 14), 0);
        cfg_load(32'($urandom), $urandom_range(18, 24), 0);
        random_sweep(3);
    endtask

    task automatic test_load_good();
        cfg_load({16'h0, 8'hA5, 8'h3C}, 16, 0);
        {c, b, a} = 3'b010;
        tick(3);
        update_model(3'b010);
        checks++; if (uo_out[1:0] !== 2'b11) begin errors++; $display("FAIL a5_3c_abc2 got %b exp 11", uo_out[1:0]); end
        checks++; if (uo_out !== exp_uo(0)) begin errors++; $display("FAIL a5_3c_uo got %h exp %h", uo_out, exp_uo(0)); end
        random_sweep(6);
        for (int j = 0; j < 4; j++) begin
            cfg_load(32'($urandom), 16, j[0]);
            random_sweep(5);
        end
    endtask

    task automatic test_hold();
        logic [7:0] snap_uo, snap_cnt;
        hold = 1;
        tick(3);
        snap_uo = uo_out; snap_cnt = uio_out;
        for (int i = 0; i < 5; i++) begin
            {c, b, a} = 3'($urandom);
            tick(2);
            checks++; if (uo_out !== snap_uo) begin errors++; $display("FAIL hold_uo got %h exp %h", uo_out, snap_uo); end
            checks++; if (uio_out !== snap_cnt) begin errors++; $display("FAIL hold_cnt got %h exp %h", uio_out, snap_cnt); end
        end
        cfg_load(32'($urandom), 16, 0);
        checks++; if (uo_out !== snap_uo) begin errors++; $display("FAIL hold_commit got %h exp %h", uo_out, snap_uo); end
        hold = 0;
        tick(2);
        checks++; if (uo_out !== snap_uo) begin errors++; $display("FAIL unhold_latency got %h exp %h", uo_out, snap_uo); end
        tick(1);
        update_model({c, b, a});
        checks++; if (uo_out !== exp_uo(0)) begin errors++; $display("FAIL unhold_uo got %h exp %h", uo_out, exp_uo(0)); end
        checks++; if (uio_out !== m_cnt) begin errors++; $display("FAIL unhold_cnt got %h exp %h", uio_out, m_cnt); end
    endtask

    task automatic test_reset_mid_load();
        cfg_en = 1;
        tick(3);
        for (int i = 0; i < 8; i++) begin
            cfg_data = 1'($urandom);
            tick(2); cfg_clk = 1; tick(2); cfg_clk = 0; tick(2);
        end
        checks++; if (uo_out[6] !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", uo_out[6]); end
        rst_n = 0;
        #1;
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL async_reset_uo got %h exp 00", uo_out); end
        checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL async_reset_cnt got %h exp 00", uio_out); end
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            {c, b, a} = i[2:0];
            tick(3);
            update_model(i[2:0]);
            checks++; if (uo_out !== exp_uo(0)) begin errors++; $display("FAIL defaults abc=%0d got %h exp %h", i, uo_out, exp_uo(0)); end
        end
        cfg_load(32'($urandom), 16, 0);
        random_sweep(5);
    endtask

    task automatic test_counter();
        logic [7:0] start;
        cfg_load({16'h0, 8'h0F, 8'h8F}, 16, 0);
        a = 0; b = 1; c = 1;
        tick(3);
        update_model(3'b110);
        start = uio_out;
        checks++; if (uio_out !== m_cnt) begin errors++; $display("FAIL cnt_start got %h exp %h", uio_out, m_cnt); end
        for (int i = 0; i < 300; i++) begin
            a = ~a;
            tick(1);
            update_model({c, b, a});
        end
        tick(3);
        checks++; if (8'(uio_out - start) !== 8'd44) begin errors++; $display("FAIL cnt_300 got %0d exp 44", 8'(uio_out - start)); end
        checks++; if (uio_out !== m_cnt) begin errors++; $display("FAIL cnt_model got %h exp %h", uio_out, m_cnt); end
        checks++; if (uo_out !== exp_uo(0)) begin errors++; $display("FAIL cnt_uo got %h exp %h", uo_out, exp_uo(0)); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_legacy_sweep();
        test_load_bad();
        test_load_good();
        test_hold();
        test_reset_mid_load();
        test_counter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
